// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-car traffic lane controller.
// Holds the lane FSM encoding, direction constants and the step-period clamp.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Step period for a level; an underflowing subtraction falls back to the floor.
   function automatic logic [31:0] clamp_period(input logic [31:0] base,
                                                input logic [31:0] step,
                                                input logic [31:0] floor_p,
                                                input logic [2:0]  level);
      logic [34:0] dec;
      logic [34:0] rem;
      dec = 35'(step) * 35'(level);
      rem = 35'(base) - dec;
      if (dec >= 35'(base) || rem < 35'(floor_p)) return floor_p;
      return rem[31:0];
   endfunction

endpackage

// File: rtl/car_span_check.sv
// Pixel and frog overlap test for one car, including the part of the car
// that wraps past the right edge back to column 0.
module car_span_check #(
   parameter int c_GAME_WIDTH = 640,
   parameter int c_CAR_WIDTH  = 64,
   parameter int c_CAR_HEIGHT = 32,
   parameter int c_FROG_SIZE  = 32
) (
   input  logic [9:0] i_Car_X,
   input  logic [9:0] i_Lane_Y,
   input  logic [9:0] i_Col,
   input  logic [9:0] i_Row,
   input  logic [9:0] i_Frog_X,
   input  logic [9:0] i_Frog_Y,
   output logic       o_Pixel_Hit,
   output logic       o_Frog_Hit
);

   localparam logic [10:0] W  = 11'(c_GAME_WIDTH);
   localparam logic [10:0] CW = 11'(c_CAR_WIDTH);
   localparam logic [10:0] CH = 11'(c_CAR_HEIGHT);
   localparam logic [10:0] FS = 11'(c_FROG_SIZE);

   logic [10:0] car_l, car_r, wrap_r, lane_t, lane_b;
   logic [10:0] col, row, frog_l, frog_r, frog_t, frog_b;
   logic        row_in, col_in, frog_rows, frog_cols;

   assign car_l  = {1'b0, i_Car_X};
   assign car_r  = car_l + CW;
   // wrap_r of 0 makes the wrapped segment empty when the car fits on screen
   assign wrap_r = (car_r > W) ? car_r - W : 11'd0;
   assign lane_t = {1'b0, i_Lane_Y};
   assign lane_b = lane_t + CH;
   assign col    = {1'b0, i_Col};
   assign row    = {1'b0, i_Row};
   assign frog_l = {1'b0, i_Frog_X};
   assign frog_r = frog_l + FS;
   assign frog_t = {1'b0, i_Frog_Y};
   assign frog_b = frog_t + FS;

   assign row_in    = (row >= lane_t) && (row < lane_b);
   assign col_in    = ((col >= car_l) && (col < car_r)) || (col < wrap_r);
   assign frog_rows = (frog_t < lane_b) && (frog_b > lane_t);
   assign frog_cols = ((frog_l < car_r) && (frog_r > car_l)) ||
                      ((frog_l < wrap_r) && (frog_r != 11'd0));

   assign o_Pixel_Hit = row_in && col_in;
   assign o_Frog_Hit  = frog_rows && frog_cols;

endmodule

// File: rtl/lane_traffic_ctrl.sv
// One lane of evenly spaced cars: level-paced stepping, wrap-aware drawing,
// and a registered frog collision that freezes the lane for a number of steps.
module lane_traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int c_GAME_WIDTH = 640,
   parameter int c_NUM_CARS   = 4,
   parameter int c_SPACING    = 160,
   parameter int c_DIRECTION  = 0,
   parameter int c_INITIAL_X  = 0,
   parameter int c_CAR_WIDTH  = 64,
   parameter int c_CAR_HEIGHT = 32,
   parameter int c_FROG_SIZE  = 32,
   parameter int c_BASE_SPEED = 1650000,
   parameter int c_SPEED_STEP = 200000,
   parameter int c_MIN_SPEED  = 250000,
   parameter int c_HIT_HOLD   = 60
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Game_Active,
   input  logic [2:0] i_Level,
   input  logic [9:0] i_Lane_Y,
   input  logic [9:0] i_Col_Count_Div,
   input  logic [9:0] i_Row_Count_Div,
   input  logic [9:0] i_Frog_X,
   input  logic [9:0] i_Frog_Y,
   output logic       o_Draw_car,
   output logic [2:0] o_Car_Index,
   output logic       o_Collision,
   output logic [9:0] o_Head_X
);

   localparam logic [10:0] W11        = 11'(c_GAME_WIDTH);
   localparam logic [9:0]  X_MAX      = 10'(c_GAME_WIDTH - 1);
   localparam logic [9:0]  X_INIT     = 10'(c_INITIAL_X);
   localparam logic        DIR        = 1'(c_DIRECTION);
   localparam logic [15:0] HOLD_LOAD  = 16'(c_HIT_HOLD);
   localparam logic [31:0] PERIOD_RST = clamp_period(32'(c_BASE_SPEED), 32'(c_SPEED_STEP),
                                                     32'(c_MIN_SPEED), 3'd0);

   state_t      state_q, state_d;
   logic [9:0]  head_q, head_d, lane_y_q, lane_y_d;
   logic [31:0] tick_q, tick_d, period_q, period_d, period_new;
   logic [15:0] hold_q, hold_d;
   logic        draw_q, draw_d, ovl_q, ovl_d, coll_q, coll_d;
   logic [2:0]  idx_q, idx_d;
   logic [9:0]  head_next;
   logic        step_tick;

   logic [c_NUM_CARS-1:0][9:0] car_x;
   logic [c_NUM_CARS-1:0]      pix_hit, frog_hit;

   for (genvar k = 0; k < c_NUM_CARS; k++) begin : g_car
      localparam logic [10:0] OFFS = 11'(k * c_SPACING);
      logic [10:0] sum;
      // head < W and OFFS < W, so one conditional subtract is a full modulo
      assign sum      = {1'b0, head_q} + OFFS;
      assign car_x[k] = (sum >= W11) ? 10'(sum - W11) : sum[9:0];

      car_span_check #(
         .c_GAME_WIDTH(c_GAME_WIDTH),
         .c_CAR_WIDTH (c_CAR_WIDTH),
         .c_CAR_HEIGHT(c_CAR_HEIGHT),
         .c_FROG_SIZE (c_FROG_SIZE)
      ) u_span (
         .i_Car_X    (car_x[k]),
         .i_Lane_Y   (lane_y_q),
         .i_Col      (i_Col_Count_Div),
         .i_Row      (i_Row_Count_Div),
         .i_Frog_X   (i_Frog_X),
         .i_Frog_Y   (i_Frog_Y),
         .o_Pixel_Hit(pix_hit[k]),
         .o_Frog_Hit (frog_hit[k])
      );
   end

   assign period_new = clamp_period(32'(c_BASE_SPEED), 32'(c_SPEED_STEP),
                                    32'(c_MIN_SPEED), i_Level);
   assign step_tick  = (tick_q == period_q);

   always_comb begin
      if (DIR == DIR_LEFT) head_next = (head_q == 10'd0) ? X_MAX : head_q - 10'd1;
      else                 head_next = (head_q == X_MAX) ? 10'd0 : head_q + 10'd1;
   end

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      head_d   = head_q;
      lane_y_d = lane_y_q;
      tick_d   = tick_q;
      period_d = period_q;
      hold_d   = hold_q;
      coll_d   = 1'b0;
      ovl_d    = |frog_hit;
      draw_d   = |pix_hit;
      idx_d    = 3'd0;
      for (int k = c_NUM_CARS - 1; k >= 0; k--) begin
         if (pix_hit[k]) idx_d = 3'(k);
      end

      if (state_q != ST_IDLE) begin
         if (step_tick) begin
            tick_d   = 32'd0;
            period_d = period_new;
         end else begin
            tick_d = tick_q + 32'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            head_d   = X_INIT;
            lane_y_d = i_Lane_Y;
            tick_d   = 32'd0;
            period_d = period_new;
            if (i_Game_Active) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (step_tick) head_d = head_next;
            if (ovl_q) begin
               state_d = ST_HIT;
               hold_d  = HOLD_LOAD;
               coll_d  = 1'b1;
            end
         end
         ST_HIT: begin
            if (step_tick) begin
               if (hold_q <= 16'd1) begin
                  hold_d  = 16'd0;
                  state_d = ST_RUN;
               end else begin
                  hold_d = hold_q - 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!i_Game_Active) begin
         state_d = ST_IDLE;
         head_d  = X_INIT;
         tick_d  = 32'd0;
         hold_d  = 16'd0;
         coll_d  = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q  <= ST_IDLE;
         head_q   <= X_INIT;
         lane_y_q <= 10'd0;
         tick_q   <= 32'd0;
         period_q <= PERIOD_RST;
         hold_q   <= 16'd0;
         draw_q   <= 1'b0;
         idx_q    <= 3'd0;
         ovl_q    <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         lane_y_q <= lane_y_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         hold_q   <= hold_d;
         draw_q   <= draw_d;
         idx_q    <= idx_d;
         ovl_q    <= ovl_d;
         coll_q   <= coll_d;
      end
   end

   assign o_Draw_car  = draw_q;
   assign o_Car_Index = idx_q;
   assign o_Collision = coll_q;
   assign o_Head_X    = head_q;

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Directed plus randomized bench for lane_traffic_ctrl: a right-moving fast lane
// and a left-moving level-paced lane, checked against a time/modulo model.
module tb_lane_traffic_ctrl;

   localparam int W = 640, N = 4, SP = 160, CW = 64, CH = 32;

   logic       clk = 1'b0;
   logic       rst, act0, act1;
   logic [2:0] lvl0, lvl1;
   logic [9:0] lane_y, col, row, frog_x, frog_y;
   logic       draw0, draw1, coll0, coll1;
   logic [2:0] idx0, idx1;
   logic [9:0] head0, head1;

   int ncomp = 0;
   int nfail = 0;
   int ec;
   int frz = 0;
   int cols_a[5] = '{600, 639, 0, 23, 24};
   int cols_b[5] = '{159, 158, 639, 62, 63};

   always #5 clk = ~clk;

   lane_traffic_ctrl #(
      .c_GAME_WIDTH(W), .c_NUM_CARS(N), .c_SPACING(SP), .c_DIRECTION(0), .c_INITIAL_X(0),
      .c_CAR_WIDTH(CW), .c_CAR_HEIGHT(CH), .c_FROG_SIZE(32),
      .c_BASE_SPEED(4), .c_SPEED_STEP(1), .c_MIN_SPEED(1), .c_HIT_HOLD(3)
   ) dut0 (
      .i_Clk(clk), .i_Rst(rst), .i_Game_Active(act0), .i_Level(lvl0), .i_Lane_Y(lane_y),
      .i_Col_Count_Div(col), .i_Row_Count_Div(row), .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
      .o_Draw_car(draw0), .o_Car_Index(idx0), .o_Collision(coll0), .o_Head_X(head0)
   );

   lane_traffic_ctrl #(
      .c_GAME_WIDTH(W), .c_NUM_CARS(N), .c_SPACING(SP), .c_DIRECTION(1), .c_INITIAL_X(0),
      .c_CAR_WIDTH(CW), .c_CAR_HEIGHT(CH), .c_FROG_SIZE(32),
      .c_BASE_SPEED(20), .c_SPEED_STEP(4), .c_MIN_SPEED(3), .c_HIT_HOLD(3)
   ) dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_Game_Active(act1), .i_Level(lvl1), .i_Lane_Y(lane_y),
      .i_Col_Count_Div(col), .i_Row_Count_Div(row), .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
      .o_Draw_car(draw1), .o_Car_Index(idx1), .o_Collision(coll1), .o_Head_X(head1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after edge n (edge 0 is the reset-release edge).
   task automatic to_edge(input int n);
      while (ec < n) begin
         @(posedge clk);
         #1;
         ec++;
      end
   endtask

   // Lowest car index covering (c, r), or -1; uses modular distance from each car.
   function automatic int model_idx(input int h, input int ly, input int c, input int r);
      int xk, d;
      model_idx = -1;
      if (r < ly || r >= ly + CH) return -1;
      for (int k = N - 1; k >= 0; k--) begin
         xk = (h + k * SP) % W;
         d  = (c - xk + W) % W;
         if (d < CW) model_idx = k;
      end
   endfunction

   // Dut0 head after edge e, given frz frozen steps so far (one step per 5 clocks).
   function automatic int head_after(input int e);
      return (e / 5 - frz) % W;
   endfunction

   // Checks dut0 draw output registered at edge e against the model.
   task automatic check_pix(input int e, input int ly);
      int h, m;
      h = ((e - 1) / 5 - frz) % W;
      m = model_idx(h, ly, int'(col), int'(row));
      check($sformatf("draw@%0d c%0d r%0d", e, col, row), 32'(draw0), 32'(m >= 0));
      check($sformatf("idx@%0d c%0d r%0d", e, col, row), 32'(idx0), 32'((m >= 0) ? m : 0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; act0 = 1'b0; act1 = 1'b0; lvl0 = 3'd0; lvl1 = 3'd0;
      lane_y = 10'd100; col = 10'd0; row = 10'd0; frog_x = 10'd0; frog_y = 10'd900;
      repeat (2) @(posedge clk);
      #1;
      check("rst_head0", 32'(head0), 32'd0);
      check("rst_draw0", 32'(draw0), 32'd0);
      check("rst_idx0",  32'(idx0),  32'd0);
      check("rst_coll0", 32'(coll0), 32'd0);
      check("rst_head1", 32'(head1), 32'd0);

      // Release reset with both lanes active
      ec = -1; rst = 1'b0; act0 = 1'b1; act1 = 1'b1;
      to_edge(4);  check("run_head_e4",  32'(head0), 32'd0);
      to_edge(5);  check("run_head_e5",  32'(head0), 32'd1);
      lvl1 = 3'd7;
      to_edge(10); check("run_head_e10", 32'(head0), 32'd2);

      // Left lane: first step wraps 0 -> 639 after the full level-0 count
      to_edge(20); check("dir1_head_e20", 32'(head1), 32'd0);
      to_edge(21); check("dir1_wrap_e21", 32'(head1), 32'd639);
      to_edge(24); check("lvl_head_e24",  32'(head1), 32'd639);
      to_edge(25); check("lvl_head_e25",  32'(head1), 32'd638);
      to_edge(29); check("lvl_head_e29",  32'(head1), 32'd637);
      act1 = 1'b0;
      to_edge(30); check("dir1_idle_head", 32'(head1), 32'd0);
      check("dir1_no_coll", 32'(coll1), 32'd0);

      to_edge(3000); check("head_600", 32'(head0), 32'(head_after(3000)));

      // Split draw across the right edge, one cycle late
      for (int i = 0; i < 5; i++) begin
         col = 10'(cols_a[i]); row = 10'd110;
         if (i == 0) begin
            #2;
            check("draw_latency", 32'(draw0), 32'd0);
         end
         to_edge(3001 + i);
         check_pix(3001 + i, 100);
      end

      // Random pixels over the lane band
      for (int e = 3006; e <= 3105; e++) begin
         col = 10'($urandom_range(639, 0));
         row = 10'($urandom_range(140, 90));
         to_edge(e);
         check_pix(e, 100);
      end

      // Frog touching the right edge of car 0 (head 621): no hit, no freeze
      frog_x = 10'd685; frog_y = 10'd110;
      for (int e = 3106; e <= 3112; e++) begin
         to_edge(e);
         if (e == 3110) frog_y = 10'd900;
         check($sformatf("touch_coll@%0d", e), 32'(coll0), 32'd0);
      end
      to_edge(3115); check("touch_head", 32'(head0), 32'(head_after(3115)));

      // Collision at head 630, hold for three step ticks
      to_edge(3150);
      frog_x = 10'd650; frog_y = 10'd110;
      to_edge(3151); check("c1_pre",   32'(coll0), 32'd0);
      to_edge(3152); check("c1_pulse", 32'(coll0), 32'd1);
      to_edge(3153); check("c1_once",  32'(coll0), 32'd0);
      frog_y = 10'd900;
      for (int e = 3154; e <= 3169; e++) begin
         to_edge(e);
         check($sformatf("c1_quiet@%0d", e), 32'(coll0), 32'd0);
      end
      check("c1_frozen", 32'(head0), 32'd630);
      frz = 3;
      to_edge(3170); check("c1_resume", 32'(head0), 32'd631);

      // Overlap registered on the same edge as a step tick
      to_edge(3173);
      frog_x = 10'd651; frog_y = 10'd110;
      to_edge(3174); check("c2_pre",   32'(coll0), 32'd0);
      to_edge(3175); check("c2_pulse", 32'(coll0), 32'd1);
      check("c2_step_taken", 32'(head0), 32'd632);
      frog_y = 10'd900;
      to_edge(3176); check("c2_once",   32'(coll0), 32'd0);
      to_edge(3194); check("c2_frozen", 32'(head0), 32'd632);
      frz = 6;
      to_edge(3195); check("c2_resume", 32'(head0), 32'(head_after(3195)));

      // Right wrap: head 639 -> 0, car 1 sits at 159
      to_edge(3225); check("wrap_head_639", 32'(head0), 32'd639);
      for (int i = 0; i < 5; i++) begin
         col = 10'(cols_b[i]); row = 10'd110;
         to_edge(3226 + i);
         check_pix(3226 + i, 100);
      end
      check("wrap_head_0", 32'(head0), 32'd0);

      // Deactivate while in HIT
      to_edge(3255); check("c3_head", 32'(head0), 32'd5);
      frog_x = 10'd25; frog_y = 10'd110;
      to_edge(3257); check("c3_pulse", 32'(coll0), 32'd1);
      act0 = 1'b0; lane_y = 10'd200; frog_y = 10'd900; col = 10'd10; row = 10'd205;
      to_edge(3258);
      check("deact_head", 32'(head0), 32'd0);
      check("deact_coll", 32'(coll0), 32'd0);
      frz = 651;
      to_edge(3259);
      check("deact_old_lane", 32'(draw0), 32'(model_idx(0, 100, 10, 205) >= 0));
      to_edge(3260);
      check("deact_new_lane_draw", 32'(draw0), 32'(model_idx(0, 200, 10, 205) >= 0));
      check("deact_new_lane_idx",  32'(idx0),  32'd0);

      // Reset mid-RUN clears everything on the same edge
      act0 = 1'b1;
      to_edge(3268);
      check("prerst_head", 32'(head0), 32'd1);
      check("prerst_draw", 32'(draw0), 32'(model_idx(1, 200, 10, 205) >= 0));
      rst = 1'b1;
      to_edge(3269);
      check("midrst_head0", 32'(head0), 32'd0);
      check("midrst_draw0", 32'(draw0), 32'd0);
      check("midrst_idx0",  32'(idx0),  32'd0);
      check("midrst_coll0", 32'(coll0), 32'd0);
      check("midrst_head1", 32'(head1), 32'd0);
      rst = 1'b0; act0 = 1'b0;
      to_edge(3271);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
